jtcontra_gfx_romarb: RTL and testbench

Three-way arbiter sharing one SDRAM graphics-ROM slot between the two 007121 tile-layer fetchers and the 007121 object engine. Each client keeps its simple cs/addr → ok/data handshake; the arbiter serialises requests onto a single memory port, caches the last word fetched per client and answers each client from that cache. Sits between the 007121 gfx blocks and the SDRAM controller slot.

---
 rtl/jtcontra_gfx_romarb_pkg.sv | 22 ++
 rtl/jtcontra_gfx_romarb_if.sv | 24 ++
 rtl/jtcontra_gfx_romarb_rr_pick.sv | 30 +++
 rtl/jtcontra_gfx_romarb.sv | 124 ++++++++++++
 tb/tb_jtcontra_gfx_romarb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jtcontra_gfx_romarb_pkg.sv
// Shared constants for the 007121 graphics ROM arbiter: client indices,
// arbiter states and the round-robin index helper.
package jtcontra_gfx_pkg;

    localparam int NCL = 3;

    localparam logic [1:0] CL_TILEA = 2'd0;
    localparam logic [1:0] CL_TILEB = 2'd1;
    localparam logic [1:0] CL_OBJ   = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Client that sits `step` places after `last` in the 0,1,2 ring.
    function automatic logic [1:0] rr_idx(input logic [1:0] last, input int step);
        return 2'((int'(last) + step) % NCL);
    endfunction

endpackage

// File: rtl/jtcontra_gfx_romarb_if.sv
// Client-side cs/addr -> ok/data handshakes and the single SDRAM slot port.
interface jtcontra_gfx_romarb_if #(
    parameter int AW = 18,
    parameter int DW = 16
);
    logic          cs0, cs1, cs2;
    logic [AW-1:0] addr0, addr1, addr2;
    logic          ok0, ok1, ok2;
    logic [DW-1:0] data0, data1, data2;
    logic          mem_cs;
    logic [AW-1:0] mem_addr;
    logic          mem_ok;
    logic [DW-1:0] mem_data;

    modport slave (
        input  cs0, cs1, cs2, addr0, addr1, addr2, mem_ok, mem_data,
        output ok0, ok1, ok2, data0, data1, data2, mem_cs, mem_addr
    );

    modport master (
        output cs0, cs1, cs2, addr0, addr1, addr2, mem_ok, mem_data,
        input  ok0, ok1, ok2, data0, data1, data2, mem_cs, mem_addr
    );
endinterface

// File: rtl/jtcontra_gfx_romarb_rr_pick.sv
// Three-way round-robin picker; during blanking the object engine pre-empts
// the tile fetchers, which then rotate between themselves only.
module jtcontra_rr_pick
    import jtcontra_gfx_pkg::*;
(
    input  logic [2:0] elig,
    input  logic [1:0] last,
    input  logic       obj_prio,
    output logic [1:0] grant,
    output logic       any
);
    logic [2:0] rr_mask;
    logic [1:0] cand;

    always_comb begin
        grant   = CL_TILEA;
        cand    = CL_TILEA;
        any     = |elig;
        rr_mask = obj_prio ? {1'b0, elig[1:0]} : elig;
        if (obj_prio && elig[CL_OBJ]) begin
            grant = CL_OBJ;
        end else begin
            // walk the ring backwards so the nearest eligible client wins
            for (int i = NCL; i >= 1; i--) begin
                cand = rr_idx(last, i);
                if (rr_mask[cand]) grant = cand;
            end
        end
    end
endmodule

// File: rtl/jtcontra_gfx_romarb.sv
// Serialises the two tile fetchers and the object engine onto one SDRAM slot,
// answering each client from a one-word cache of its last fetched address.
module jtcontra_gfx_romarb
    import jtcontra_gfx_pkg::*;
#(
    parameter int AW = 18,
    parameter int DW = 16
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   LHBL,
    jtcontra_gfx_romarb_if.slave   bus
);
    logic [NCL-1:0]         cs;
    logic [NCL-1:0][AW-1:0] addr;
    logic [NCL-1:0]         ok_w;
    logic [NCL-1:0]         elig;
    logic [DW-1:0]          data_w [NCL];

    state_e        state_q, state_d;
    logic [1:0]    grant_q, grant_d, last_q, last_d, pick;
    logic          mem_cs_q, mem_cs_d, any, fill;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    assign cs   = {bus.cs2, bus.cs1, bus.cs0};
    assign addr = {bus.addr2, bus.addr1, bus.addr0};

    assign bus.ok0      = ok_w[CL_TILEA];
    assign bus.ok1      = ok_w[CL_TILEB];
    assign bus.ok2      = ok_w[CL_OBJ];
    assign bus.data0    = data_w[CL_TILEA];
    assign bus.data1    = data_w[CL_TILEB];
    assign bus.data2    = data_w[CL_OBJ];
    assign bus.mem_cs   = mem_cs_q;
    assign bus.mem_addr = mem_addr_q;

    // ok depends only on client inputs and cache flops, never on mem_*
    for (genvar n = 0; n < NCL; n++) begin : g_cache
        logic          vld_q, vld_d;
        logic [AW-1:0] tag_q, tag_d;
        logic [DW-1:0] data_q, data_d;
        logic          hit;

        assign hit       = vld_q && (addr[n] == tag_q);
        assign ok_w[n]   = cs[n] && hit;
        assign elig[n]   = cs[n] && !hit;
        assign data_w[n] = data_q;

        always_comb begin
            vld_d  = vld_q;
            tag_d  = tag_q;
            data_d = data_q;
            if (fill && grant_q == 2'(n)) begin
                vld_d  = 1'b1;
                tag_d  = mem_addr_q;
                data_d = bus.mem_data;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q  <= 1'b0;
                tag_q  <= '0;
                data_q <= '0;
            end else begin
                vld_q  <= vld_d;
                tag_q  <= tag_d;
                data_q <= data_d;
            end
        end
    end

    jtcontra_rr_pick u_pick (
        .elig     (elig),
        .last     (last_q),
        .obj_prio (!LHBL),
        .grant    (pick),
        .any      (any)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        mem_cs_d   = mem_cs_q;
        mem_addr_d = mem_addr_q;
        fill       = 1'b0;
        case (state_q)
            IDLE: if (any) begin
                grant_d    = pick;
                mem_addr_d = addr[pick];
                mem_cs_d   = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (bus.mem_ok) begin
                fill     = 1'b1;
                mem_cs_d = 1'b0;
                state_d  = GAP;
            end
            // one low cycle so the slot sees a fresh request edge
            GAP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= CL_TILEA;
            last_q     <= CL_OBJ;
            mem_cs_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            mem_cs_q   <= mem_cs_d;
            mem_addr_q <= mem_addr_d;
        end
    end
endmodule

// File: tb/tb_jtcontra_gfx_romarb.sv
// Directed scenarios followed by random traffic, all checked every cycle
// against a transaction-level model of the arbiter and its client caches.
module tb_jtcontra_gfx_romarb;
    localparam int AW = 18;
    localparam int DW = 16;

    logic rst, clk, lhbl;
    jtcontra_gfx_romarb_if #(.AW(AW), .DW(DW)) bus ();

    jtcontra_gfx_romarb #(.AW(AW), .DW(DW)) dut (
        .rst  (rst),
        .clk  (clk),
        .LHBL (lhbl),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus variables, applied on the falling edge
    logic          rst_v, lhbl_v, mok_v;
    logic [2:0]    cs_v;
    logic [AW-1:0] addr_v [3];
    logic [DW-1:0] mdata_v;

    // reference model: per-client cache word and the slot's transaction phase
    logic          m_vld  [3];
    logic [AW-1:0] m_tag  [3];
    logic [DW-1:0] m_data [3];
    int            m_ph;      // 0 free, 1 request outstanding, 2 turnaround
    int            m_g, m_last;
    logic [AW-1:0] m_addr;

    // DUT outputs as seen at the last sampling point
    logic          s_mem_cs;
    logic [AW-1:0] s_mem_addr;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int n = 0; n < 3; n++) begin
            m_vld[n] = 1'b0; m_tag[n] = '0; m_data[n] = '0;
        end
        m_ph = 0; m_g = 0; m_last = 2; m_addr = '0;
    endfunction

    function automatic logic m_hit(input int n);
        return m_vld[n] && addr_v[n] == m_tag[n];
    endfunction

    // one clock edge of the model, using the inputs the DUT sees at that edge
    function automatic void model_edge();
        logic [2:0] want;
        int pick;
        if (rst_v) begin
            model_reset();
            return;
        end
        if (m_ph == 1) begin
            if (mok_v) begin
                m_vld[m_g] = 1'b1; m_tag[m_g] = m_addr; m_data[m_g] = mdata_v;
                m_ph = 2;
            end
        end else if (m_ph == 2) begin
            m_last = m_g;
            m_ph = 0;
        end else begin
            for (int n = 0; n < 3; n++) want[n] = cs_v[n] && !m_hit(n);
            pick = -1;
            if (!lhbl_v && want[2]) pick = 2;
            else
                for (int i = 1; i <= 3; i++)
                    if (pick < 0 && want[(m_last + i) % 3] && (lhbl_v || (m_last + i) % 3 != 2))
                        pick = (m_last + i) % 3;
            if (pick >= 0) begin
                m_g = pick; m_addr = addr_v[pick]; m_ph = 1;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [2:0]    ok;
        logic [DW-1:0] dat [3];
        ok = {bus.ok2, bus.ok1, bus.ok0};
        dat[0] = bus.data0; dat[1] = bus.data1; dat[2] = bus.data2;
        s_mem_cs = bus.mem_cs;
        s_mem_addr = bus.mem_addr;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("ok%0d", n), 32'(ok[n]), 32'(cs_v[n] && m_hit(n)));
            chk($sformatf("data%0d", n), 32'(dat[n]), 32'(m_data[n]));
        end
        chk("mem_cs", 32'(s_mem_cs), 32'(m_ph == 1));
        if (m_ph == 1) chk("mem_addr", 32'(s_mem_addr), 32'(m_addr));
    endtask

    task automatic step();
        @(negedge clk);
        rst = rst_v; lhbl = lhbl_v;
        bus.cs0 = cs_v[0]; bus.cs1 = cs_v[1]; bus.cs2 = cs_v[2];
        bus.addr0 = addr_v[0]; bus.addr1 = addr_v[1]; bus.addr2 = addr_v[2];
        bus.mem_ok = mok_v; bus.mem_data = mdata_v;
        if (rst_v) model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
    endtask

    task automatic wait_req(input string tag, input logic [AW-1:0] exp_a);
        int n = 0;
        step();
        while (!s_mem_cs && n < 12) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(s_mem_cs), 32'd1);
        chk({tag, "_addr"}, 32'(s_mem_addr), 32'(exp_a));
    endtask

    task automatic complete(input int lat, input logic [DW-1:0] d);
        repeat (lat) step();
        mok_v = 1'b1; mdata_v = d;
        step();
        mok_v = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [AW-1:0] exp_a, input logic [DW-1:0] d);
        wait_req(tag, exp_a);
        complete(int'($urandom_range(0, 3)), d);
    endtask

    task automatic do_reset();
        rst_v = 1'b1;
        step();
        chk("rst_mem_addr", 32'(s_mem_addr), 32'd0);
        step();
        rst_v = 1'b0;
    endtask

    initial begin
        rst_v = 1'b1; lhbl_v = 1'b1; mok_v = 1'b0; cs_v = '0; mdata_v = '0;
        for (int n = 0; n < 3; n++) addr_v[n] = '0;
        model_reset();
        rst = 1'b1; lhbl = 1'b1;
        do_reset();

        // first fetch: 4-cycle SDRAM latency
        cs_v[0] = 1'b1; addr_v[0] = 18'h00123;
        wait_req("first", 18'h00123);
        complete(3, 16'hBEEF);
        step();
        chk("first_ok0", 32'(bus.ok0), 32'd1);
        chk("first_data0", 32'(bus.data0), 32'hBEEF);
        chk("first_gap", 32'(s_mem_cs), 32'd0);

        // full round robin from a fresh last=2
        do_reset();
        lhbl_v = 1'b1; cs_v = 3'b111;
        addr_v[0] = 18'h10; addr_v[1] = 18'h20; addr_v[2] = 18'h30;
        fetch("rr_a0", 18'h10, 16'h1000);
        fetch("rr_a1", 18'h20, 16'h2000);
        fetch("rr_a2", 18'h30, 16'h3000);
        addr_v[0] = 18'h11; addr_v[1] = 18'h21; addr_v[2] = 18'h31;
        fetch("rr_b0", 18'h11, 16'h1001);
        fetch("rr_b1", 18'h21, 16'h2001);
        fetch("rr_b2", 18'h31, 16'h3001);

        // blanking: obj pre-empts, tile B waits until obj is satisfied
        lhbl_v = 1'b0;
        addr_v[0] = 18'h50; addr_v[2] = 18'h70;
        fetch("blk_obj", 18'h70, 16'h7000);
        fetch("blk_t0", 18'h50, 16'h5000);
        addr_v[1] = 18'h60; addr_v[2] = 18'h71;
        fetch("blk_obj2", 18'h71, 16'h7001);
        addr_v[2] = 18'h72;
        fetch("blk_obj3", 18'h72, 16'h7002);
        fetch("blk_t1", 18'h60, 16'h6000);

        // object engine cs toggle pattern at the top of the address space
        addr_v[2] = 18'h3FFF0;
        fetch("obj_a", 18'h3FFF0, 16'hA5A0);
        step();
        chk("obj_ok_a", 32'(bus.ok2), 32'd1);
        cs_v[2] = 1'b0; step();
        cs_v[2] = 1'b1; addr_v[2] = 18'h3FFF1; step();
        chk("obj_ok_miss", 32'(bus.ok2), 32'd0);
        fetch("obj_b", 18'h3FFF1, 16'hA5A1);
        step();
        chk("obj_ok_b", 32'(bus.ok2), 32'd1);
        cs_v[2] = 1'b0; step();
        cs_v[2] = 1'b1; step();
        chk("obj_hit_ok", 32'(bus.ok2), 32'd1);
        chk("obj_hit_nocs", 32'(s_mem_cs), 32'd0);

        // tile B moves on while its fetch is in flight
        lhbl_v = 1'b1;
        addr_v[1] = 18'h40;
        wait_req("stale", 18'h40);
        addr_v[1] = 18'h41;
        complete(1, 16'h1111);
        step();
        chk("stale_ok1", 32'(bus.ok1), 32'd0);
        fetch("refetch", 18'h41, 16'h2222);
        step();
        chk("refetch_ok1", 32'(bus.ok1), 32'd1);
        chk("refetch_data1", 32'(bus.data1), 32'h2222);

        // asynchronous reset in the middle of a fetch
        cs_v = 3'b001; addr_v[0] = 18'h90;
        wait_req("rstw", 18'h90);
        rst_v = 1'b1;
        step();
        chk("rstw_cs", 32'(s_mem_cs), 32'd0);
        chk("rstw_ok", 32'({bus.ok2, bus.ok1, bus.ok0}), 32'd0);
        step();
        rst_v = 1'b0;
        fetch("rstw_resume", 18'h90, 16'h9090);

        // random traffic, including spurious mem_ok and stray resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) lhbl_v = ~lhbl_v;
            for (int n = 0; n < 3; n++) begin
                if ($urandom_range(0, 7) == 0) cs_v[n] = ~cs_v[n];
                if ($urandom_range(0, 5) == 0)
                    addr_v[n] = ($urandom_range(0, 4) == 0) ? 18'h3FFFF
                              : 18'(n * 16 + int'($urandom_range(0, 3)));
            end
            mok_v = ($urandom_range(0, 2) == 0);
            mdata_v = 16'($urandom);
            rst_v = ($urandom_range(0, 499) == 0);
            step();
        end
        rst_v = 1'b0; mok_v = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
